bht_ctrl: RTL and testbench
===========================

Name: bht_ctrl

Overview:
- Branch history table controller. Owns a table of 2-bit saturating counters indexed by PC and serves one prediction lookup per cycle to IF.
- Accepts resolved-branch feedback from EX through a 2-entry update queue and applies one counter update per cycle.
- Sequences a table-initialisation sweep after reset and after flush, and arbitrates the single table write port between the sweep and feedback updates.

Parameters:
- PC_W, 32, PC width in bits.
- IDX_W, 6, table index width; table holds 2**IDX_W counters.
- INIT_CNT, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lookup_valid  in  1  prediction request this cycle
- lookup_pc  in  PC_W  PC of the fetched instruction
- pred_valid  out  1  prediction result valid, one cycle after the request
- pred_taken  out  1  predicted direction
- upd_valid  in  1  feedback present
- upd_ready  out  1  feedback accepted this cycle
- upd_pc  in  PC_W  PC of the resolved branch
- upd_taken  in  1  actual branch outcome
- flush  in  1  re-initialise the table; drop pending feedback
- init_busy  out  1  init sweep in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pred_valid=0, pred_taken=0, init_busy=1, state=INIT, sweep pointer=0, queue empty. Table storage is not reset; the sweep initialises it.
- Index: pc[IDX_W+1:2], word-aligned. Higher PC bits are ignored, so aliasing is allowed.
- FSM states: INIT and RUN.
  - INIT: each cycle, write INIT_CNT to table[ptr] and increment ptr. After writing entry 2**IDX_W-1, go to RUN and set ptr to 0. init_busy = (state==INIT), so it is high for exactly 2**IDX_W cycles after reset release.
  - RUN: when flush=1, go to INIT with ptr=0 on the next edge.
- Write port arbitration: only the sweep writes in INIT. In RUN, if the queue is non-empty, pop the head and write table[idx] with the saturating update.
- Saturating update: taken gives cnt+1, capped at 3. Not-taken gives cnt-1, floored at 0.
- Update queue:
  - 2-entry FIFO holding {idx, taken}. upd_ready = !full.
  - An update is accepted when upd_valid && upd_ready. When the queue is full, an update is not accepted even if a pop happens in the same cycle (no pass-through).
  - Accept and pop in the same cycle are allowed.
  - In RUN, an update accepted in cycle N is applied to the table at the end of cycle N+1 at the earliest.
  - In INIT, updates accumulate until full, then upd_ready=0.
- Lookup:
  - Registered, 1-cycle latency. pred_valid(N+1) = lookup_valid(N).
  - pred_taken(N+1) = table[idx][1] read in cycle N, using the value before any write committed at the end of cycle N. There is no write-to-read bypass.
  - If the state is INIT in cycle N, pred_taken(N+1)=0.
  - When lookup_valid=0, pred_taken holds its last value.
- Flush:
  - All queue entries are discarded at the flush edge.
  - An update handshaked in the flush cycle is dropped.
  - A pop/write scheduled in the flush cycle still completes.
  - flush during INIT restarts the sweep at ptr=0.
- Reset mid-operation: all state returns to reset values immediately. The sweep restarts after release.
- Counter width is 2 bits; wrap-around never occurs, only saturation.

Test Plan:
- Reset release with IDX_W=6 -> init_busy high exactly 64 cycles. Lookups during the sweep give pred_valid next cycle with pred_taken=0. upd_ready=1 until 2 updates are queued, then 0.
- After the sweep, 2 taken updates at pc 0x40 (idx 16), then lookup of 0x40 -> counter goes 01→10→11. pred_taken=1 on the lookup issued 2 cycles after the second accept. A lookup issued the cycle after the first accept returns 0 (no bypass).
- Saturation: 4 taken updates on idx 5, then 4 not-taken -> counter pins at 3, then decays 3→2→1→0. pred_taken toggles to 0 after the second not-taken is applied.
- Aliasing: update pc 0x0000_0104 taken twice; lookup pc 0x0001_0104 (same idx 1) -> pred_taken=1.
- Flush with 2 entries queued and upd_valid=1 in the same cycle -> queue empties, init_busy=1 for 64 cycles, all counters return to 01. The dropped updates have no effect.
- Assert rst_n low mid-sweep at ptr=30 -> outputs return to reset values asynchronously. After release, the sweep restarts at 0 and lasts a full 64 cycles.

Source files
------------

// File: rtl/bht_ctrl.sv
// Branch history table of 2-bit saturating counters with a registered lookup port,
// a 2-entry feedback queue and a post-reset/flush initialisation sweep.
module bht_ctrl #(
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            flush,
    output logic            init_busy
);
    localparam int DEPTH = 2**IDX_W;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] ptr, next_ptr;
    logic [1:0]       tbl [DEPTH];

    logic [IDX_W-1:0] q_idx [2];
    logic             q_tkn [2];
    logic [1:0]       q_cnt;
    logic             q_head;
    logic             q_tail;
    logic             push;
    logic             pop;
    logic             sweep_we;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             pc_unused;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
        return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    endfunction

    // Word-aligned index; upper PC bits alias onto the same counter.
    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign pc_unused  = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                          upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        case (state)
            INIT: begin
                if (flush) begin
                    next_ptr = '0;
                end else if (&ptr) begin
                    next_state = RUN;
                    next_ptr   = '0;
                end else begin
                    next_ptr = ptr + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    next_state = INIT;
                    next_ptr   = '0;
                end
            end
            default: begin
                next_state = INIT;
                next_ptr   = '0;
            end
        endcase
    end

    always_comb begin
        init_busy = (state == INIT);
        sweep_we  = (state == INIT);
        upd_ready = (q_cnt != 2'd2);
        pop       = (state == RUN) && (q_cnt != 2'd0);
        push      = upd_valid && upd_ready && !flush;
    end

    // A full queue never accepts, even when popping in the same cycle.
    assign q_tail  = q_head ^ q_cnt[0];
    assign pop_idx = q_idx[q_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt  <= 2'd0;
            q_head <= 1'b0;
        end else if (flush) begin
            q_cnt  <= 2'd0;
            q_head <= 1'b0;
        end else begin
            q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
            if (pop)
                q_head <= ~q_head;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[q_tail] <= upd_idx;
            q_tkn[q_tail] <= upd_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_we)
            tbl[ptr] <= INIT_CNT;
        else if (pop)
            tbl[pop_idx] <= sat_update(tbl[pop_idx], q_tkn[q_head]);
    end

    // Lookup reads the pre-write table value; no bypass from the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= lookup_valid;
            if (lookup_valid)
                pred_taken <= (state == RUN) && tbl[lookup_idx][1];
        end
    end
endmodule

// File: tb/tb_bht_ctrl.sv
// Randomised scoreboard bench for bht_ctrl against a queue/array reference model.
module tb_bht_ctrl;
    localparam int PC_W  = 32;
    localparam int IDX_W = 6;
    localparam int N     = 2**IDX_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            lookup_valid = 1'b0;
    logic [PC_W-1:0] lookup_pc = '0;
    logic            pred_valid;
    logic            pred_taken;
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [PC_W-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic            flush = 1'b0;
    logic            init_busy;

    bht_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .INIT_CNT(2'b01)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_taken(upd_taken),
        .flush(flush), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { int idx; bit tkn; } upd_t;
    bit   exp_q[$];
    int   m_tbl[N];
    bit   m_init = 1'b1;
    int   m_ptr = 0;
    upd_t m_q[$];
    upd_t m_u;
    bit   m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle when inputs and outputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_init = 1'b1;
            m_ptr  = 0;
            m_q.delete();
        end else begin
            check("init_busy", init_busy, m_init);
            check("upd_ready", upd_ready, m_q.size() < 2);
            if (lookup_valid)
                exp_q.push_back(m_init ? 1'b0 : (m_tbl[lookup_pc[IDX_W+1:2]] >= 2));
            m_acc = upd_valid && (m_q.size() < 2) && !flush;
            if (!m_init && m_q.size() > 0) begin
                m_u = m_q.pop_front();
                if (m_u.tkn) m_tbl[m_u.idx] = (m_tbl[m_u.idx] >= 3) ? 3 : m_tbl[m_u.idx] + 1;
                else         m_tbl[m_u.idx] = (m_tbl[m_u.idx] <= 0) ? 0 : m_tbl[m_u.idx] - 1;
            end
            if (m_init)
                m_tbl[m_ptr] = 1;
            if (flush) begin
                m_q.delete();
                m_init = 1'b1;
                m_ptr  = 0;
            end else begin
                if (m_acc)
                    m_q.push_back('{idx: int'(upd_pc[IDX_W+1:2]), tkn: upd_taken});
                if (m_init) begin
                    if (m_ptr == N-1) begin
                        m_init = 1'b0;
                        m_ptr  = 0;
                    end else begin
                        m_ptr++;
                    end
                end
            end
        end
    end

    // Monitor: compares each presented prediction against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (pred_valid) begin
                if (exp_q.size() == 0)
                    check("pred_spurious", pred_valid, 1'b0);
                else
                    check("pred_taken", pred_taken, exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                check("pred_valid", pred_valid, 1'b1);
                exp_q.delete();
            end
        end
    end

    task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv,
                         input logic [31:0] upc, input bit ut, input bit fl);
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_taken    = ut;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] r;
        r = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 7)) << 2);
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_init_busy", init_busy, 1'b1);
        check("reset_pred_valid", pred_valid, 1'b0);
        check("reset_pred_taken", pred_taken, 1'b0);
        check("reset_upd_ready", upd_ready, 1'b1);
        rst_n = 1'b1;

        // Sweep after reset: lookups and queued feedback.
        for (int i = 0; i < N + 2; i++)
            drive($urandom_range(0, 1), rnd_pc(), 1'b1, rnd_pc(), $urandom_range(0, 1), 1'b0);
        idle(4);

        // Two taken updates at idx 16, lookups before and after they land.
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);

        // Saturation and decay on idx 5.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h14, 1'b1, 32'h14, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h14, 1'b1, 32'h14, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0);

        // Aliasing through ignored upper PC bits.
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0104, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0104, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 32'h0001_0104, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1);

        // Flush with a full queue and a handshake in the flush cycle.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 1'b1);
        for (int i = 0; i < N + 4; i++) drive(1'b1, 32'(i % N) << 2, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) drive(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0, 1'b0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 1), rnd_pc(), $urandom_range(0, 1), rnd_pc(),
                  $urandom_range(0, 1), ($urandom_range(0, 149) == 0));
        idle(N + 4);

        // Make pred_taken high, then reset mid-sweep at ptr 30.
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) drive(1'b0, 32'h0, 1'b1, rnd_pc(), 1'b1, 1'b0);
        check("pred_hold", pred_taken, 1'b1);
        check("busy_before_rst", upd_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_init_busy", init_busy, 1'b1);
        check("async_rst_pred_valid", pred_valid, 1'b0);
        check("async_rst_pred_taken", pred_taken, 1'b0);
        check("async_rst_upd_ready", upd_ready, 1'b1);
        upd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N + 4; i++) drive(1'b1, 32'(i % N) << 2, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) drive(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
